t06_spawn_arbiter: RTL and testbench
====================================

T06_SPAWN_ARBITER -- requirements
Module: t06_spawn_arbiter

Interface
REQ-001 Parameter MAX_TRIES, default 8: rejected draws allowed before a failed completion; legal range 1..15.
REQ-002 Parameter LFSR_SEED, default 8'd2: LFSR value loaded on reset.
REQ-003 Port system_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port nreset  input  1  reset, asynchronous, active-low.
REQ-005 Port apple_req  input  1  apple spawn request; held high until done with done_id=0.
REQ-006 Port wall_req  input  1  wall spawn request; held high until done with done_id=1.
REQ-007 Port occupied  input  1  cell occupancy for query_x/query_y; valid the cycle after query_valid.
REQ-008 Port query_valid  output  1  occupancy query strobe, one cycle.
REQ-009 Port query_x / query_y  output  4 each  cell being queried.
REQ-010 Port done  output  1  one-cycle completion pulse.
REQ-011 Port done_id  output  1  served requester: 0=apple, 1=wall; valid with done.
REQ-012 Port done_fail  output  1  high with done when MAX_TRIES draws were rejected.
REQ-013 Port pos_x / pos_y  output  4 each  spawn cell; valid with done, held until next done.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 Internal 8-bit LFSR SHALL advance every clock: next = {n[6:0], ~(n[6]^n[5])}, period 127.
REQ-016 Draw mapping SHALL be x = lfsr[7:4], y = lfsr[3:0].
REQ-017 FSM states SHALL be IDLE, DRAW, QUERY, CHECK, DONE.
REQ-018 IDLE: on an edge with any request high -> DRAW; the winner's id is latched, tries cleared.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; last-served resets to wall, so apple wins first.
REQ-020 DRAW: the LFSR value present in the cycle is latched into query_x/query_y; -> QUERY.
REQ-021 QUERY: query_valid=1 for exactly one cycle; -> CHECK.
REQ-022 CHECK: occupied=0 -> DONE, success; occupied=1 -> tries+1; if tries+1 == MAX_TRIES -> DONE, fail, else -> DRAW.
REQ-023 DONE: done=1 for one cycle; pos_x/pos_y = last drawn cell (also on fail); last-served updated; -> IDLE.
REQ-024 First-try latency: done high in the 4th cycle after the sampling edge.
REQ-025 A request dropped mid-service SHALL NOT abort the service; done still pulses.
REQ-026 Requests arriving while busy SHALL wait; they are not queued beyond the held level.

Reset
REQ-027 nreset low SHALL asynchronously force IDLE, LFSR=LFSR_SEED, tries=0, last-served=wall.
REQ-028 nreset low SHALL force all outputs to 0, including mid-service; the in-flight request is discarded.

Configuration
REQ-029 Macro T06_SPAWN_BORDER_EXCLUDE_EN defined: in DRAW a cell with x or y equal to 0 or 15 SHALL count as rejected (tries+1, same MAX_TRIES rule), stay in DRAW and issue no query.
REQ-030 Macro T06_SPAWN_BORDER_EXCLUDE_EN undefined: all 256 cells are eligible and border logic is absent.

Structure
REQ-031 Package t06_spawn_pkg SHALL hold the state enum, ID_APPLE/ID_WALL constants and COORD_W=4.
REQ-032 The LFSR SHALL be the sub-module t06_spawn_lfsr (seed parameter, free-running 8-bit output).

Verification
REQ-033 Reset: nreset low mid-run -> all outputs 0; after release, LFSR sequence 0x02, 0x05, 0x0B, 0x17, 0x2F, 0x5E.
REQ-034 Macro off, apple_req high at the first edge after reset release, occupied=0 -> query (0,5), then done=1, done_id=0, done_fail=0, pos=(0,5).
REQ-035 apple_req and wall_req high together, occupied=0 -> apple done first, then wall done; no overlap; busy low for one cycle between services.
REQ-036 occupied tied 1, MAX_TRIES=8 -> exactly 8 query_valid pulses, then done=1, done_fail=1.
REQ-037 Macro on, same stimulus as REQ-034 -> no query for (0,5); the first query is a non-border cell.
REQ-038 nreset pulsed while in CHECK -> immediate IDLE, done never pulses, a held request is re-served with apple priority.

Source files
------------

// File: rtl/t06_spawn_pkg.sv
// Shared types and constants for the spawn arbiter.
// The border helper exists only when T06_SPAWN_BORDER_EXCLUDE_EN is defined.
package t06_spawn_pkg;

  localparam int COORD_W = 4;

  localparam logic ID_APPLE = 1'b0;
  localparam logic ID_WALL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    QUERY,
    CHECK,
    DONE
  } state_t;

`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
  // A cell on the outer ring of the 16x16 field is never a legal spawn cell.
  function automatic logic is_border(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (x == '0) || (x == '1) || (y == '0) || (y == '1);
  endfunction
`endif

endpackage

// File: rtl/t06_spawn_lfsr.sv
// Free-running 8-bit XNOR LFSR (period 127) used as the spawn-cell source.
module t06_spawn_lfsr #(
  parameter logic [7:0] LFSR_SEED = 8'd2
) (
  input  logic       system_clk,
  input  logic       nreset,
  output logic [7:0] value
);

  // Advance every clock; reload the seed on reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, independent of block ordering.
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) value <= LFSR_SEED;
    else         value <= {value[6:0], ~(value[6] ^ value[5])};
  end

endmodule

// File: rtl/t06_spawn_arbiter.sv
// Round-robin spawn arbiter: serves apple/wall requests by drawing random
// cells from an LFSR and querying occupancy until a free cell is found or
// MAX_TRIES draws have been rejected.
// Optional feature: T06_SPAWN_BORDER_EXCLUDE_EN rejects border cells in DRAW.
module t06_spawn_arbiter
  import t06_spawn_pkg::*;
#(
  parameter int         MAX_TRIES = 8,
  parameter logic [7:0] LFSR_SEED = 8'd2
) (
  input  logic               system_clk,
  input  logic               nreset,
  input  logic               apple_req,
  input  logic               wall_req,
  input  logic               occupied,
  output logic               query_valid,
  output logic [COORD_W-1:0] query_x,
  output logic [COORD_W-1:0] query_y,
  output logic               done,
  output logic               done_id,
  output logic               done_fail,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               busy
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [7:0] lfsr;
  logic [3:0] tries_q;
  logic       id_q, fail_q, last_q;
  logic       start, reject, finish, finish_fail, winner, last_try;
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
  logic       finish_from_draw;
`endif

  t06_spawn_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .system_clk (system_clk),
    .nreset     (nreset),
    .value      (lfsr)
  );

  assign last_try = (tries_q + 4'd1) == MAX_T;

  // The requester not served last wins a tie.
  assign winner = (apple_req && wall_req) ? ((last_q == ID_WALL) ? ID_APPLE : ID_WALL)
                                          : (apple_req ? ID_APPLE : ID_WALL);

  assign busy        = (state_q != IDLE);
  assign query_valid = (state_q == QUERY);
  assign done        = (state_q == DONE);
  assign done_id     = done & id_q;
  assign done_fail   = done & fail_q;

  // State register.
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath control decode.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    reject      = 1'b0;
    finish      = 1'b0;
    finish_fail = 1'b0;
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
    finish_from_draw = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (apple_req || wall_req) begin
          start   = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
        if (is_border(lfsr[7:4], lfsr[3:0])) begin
          reject = 1'b1;
          if (last_try) begin
            finish           = 1'b1;
            finish_fail      = 1'b1;
            finish_from_draw = 1'b1;
            state_d          = DONE;
          end
        end else begin
          state_d = QUERY;
        end
`else
        state_d = QUERY;
`endif
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        if (!occupied) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          reject = 1'b1;
          if (last_try) begin
            finish      = 1'b1;
            finish_fail = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Service bookkeeping: winner id, try counter, drawn cell, result cell.
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      tries_q <= '0;
      id_q    <= ID_APPLE;
      fail_q  <= 1'b0;
      last_q  <= ID_WALL;
      query_x <= '0;
      query_y <= '0;
      pos_x   <= '0;
      pos_y   <= '0;
    end else begin
      if (start) begin
        id_q    <= winner;
        tries_q <= '0;
      end else if (reject) begin
        tries_q <= tries_q + 4'd1;
      end
      if (state_q == DRAW) begin
        query_x <= lfsr[7:4];
        query_y <= lfsr[3:0];
      end
      if (finish) begin
        fail_q <= finish_fail;
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
        if (finish_from_draw) begin
          pos_x <= lfsr[7:4];
          pos_y <= lfsr[3:0];
        end else begin
          pos_x <= query_x;
          pos_y <= query_y;
        end
`else
        pos_x <= query_x;
        pos_y <= query_y;
`endif
      end
      if (state_q == DONE) last_q <= id_q;
    end
  end

endmodule

// File: tb/tb_t06_spawn_arbiter.sv
// Self-checking bench for t06_spawn_arbiter (default parameters).
// Honours T06_SPAWN_BORDER_EXCLUDE_EN in its reference model.
module tb_t06_spawn_arbiter;

  localparam int         MAX  = 8;
  localparam logic [7:0] SEED = 8'h02;

  logic       system_clk = 1'b0;
  logic       nreset     = 1'b0;
  logic       apple_req  = 1'b0;
  logic       wall_req   = 1'b0;
  logic       occupied   = 1'b0;
  logic       query_valid, done, done_id, done_fail, busy;
  logic [3:0] query_x, query_y, pos_x, pos_y;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  logic [7:0] exp_q[$];

  typedef struct {
    int         delay;
    logic       apple;
    logic       wall;
    logic       occ;
    logic       exp_id;
    logic       exp_fail;
    logic [7:0] exp_first;
    int         exp_nq;
  } vec_t;

  vec_t vecs[5];

  t06_spawn_arbiter dut (
    .system_clk  (system_clk),
    .nreset      (nreset),
    .apple_req   (apple_req),
    .wall_req    (wall_req),
    .occupied    (occupied),
    .query_valid (query_valid),
    .query_x     (query_x),
    .query_y     (query_y),
    .done        (done),
    .done_id     (done_id),
    .done_fail   (done_fail),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .busy        (busy)
  );

  always #5 system_clk = ~system_clk;

  // Edge count since reset release: in the cycle after edge k, cyc == k.
  always @(posedge system_clk or negedge nreset) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < k; i++) v = {v[6:0], ~(v[6] ^ v[5])};
    return v;
  endfunction

  function automatic logic tb_border(input logic [7:0] v);
    logic [3:0] x, y;
    x = v[7:4];
    y = v[3:0];
    return (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15);
  endfunction

  // Reference model of one service whose DRAW cycle carries LFSR index s.
  // Pushes the expected query cells and returns the expected completion.
  task automatic predict(input int s, input logic occ, output int dcyc,
                         output logic fail, output logic [7:0] pos);
    int         idx, tries;
    bit         fin;
    logic [7:0] v;
    exp_q.delete();
    idx = s; tries = 0; fin = 0; dcyc = 0; fail = 1'b0; pos = 8'h00;
    for (int g = 0; g < 64 && !fin; g++) begin
      v = lfsr_at(idx);
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
      if (tb_border(v)) begin
        tries++;
        if (tries == MAX) begin fin = 1; fail = 1'b1; pos = v; dcyc = idx + 1; end
        else idx++;
      end else
`endif
      begin
        exp_q.push_back(v);
        if (!occ) begin
          fin = 1; pos = v; dcyc = idx + 3;
        end else begin
          tries++;
          if (tries == MAX) begin fin = 1; fail = 1'b1; pos = v; dcyc = idx + 3; end
          else idx += 3;
        end
      end
    end
  endtask

  // Watch one service, compare queries and completion against the model.
  task automatic serve(input logic exp_id, input int s, input logic occ, input bit drop,
                       output logic [7:0] first_q, output int nq);
    int         dcyc;
    logic       efail;
    logic [7:0] epos, e;
    bit         got;
    predict(s, occ, dcyc, efail, epos);
    got = 0; nq = 0; first_q = 8'h00;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge system_clk);
      if (query_valid) begin
        if (nq == 0) first_q = {query_x, query_y};
        nq++;
        if (exp_q.size() == 0) check("extra_query", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("query_xy", {query_x, query_y}, e);
`ifdef T06_SPAWN_BORDER_EXCLUDE_EN
          check("query_not_border", tb_border({query_x, query_y}), 1'b0);
`endif
        end
      end
      if (done) begin
        got = 1;
        check("done_cycle", cyc, dcyc);
        check("done_id", done_id, exp_id);
        check("done_fail", done_fail, efail);
        check("pos_xy", {pos_x, pos_y}, epos);
        check("busy_in_done", busy, 1'b1);
        if (drop) begin
          if (exp_id) wall_req = 1'b0;
          else        apple_req = 1'b0;
        end
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("queries_left", exp_q.size(), 32'd0);
  endtask

  task automatic outputs_zero(input string name);
    check(name, {busy, query_valid, done, done_id, done_fail,
                 query_x, query_y, pos_x, pos_y}, 32'd0);
  endtask

  // Assert reset between edges, check outputs, release on a falling edge.
  task automatic do_reset();
    @(negedge system_clk);
    nreset = 1'b0;
    #2;
    outputs_zero("reset_outputs");
    @(negedge system_clk);
    @(negedge system_clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic [7:0] fq;
    int         nq;
    bit         found;

    vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1};
    vecs[1] = '{1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0B, 1};
    vecs[2] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h17, 1};
    vecs[3] = '{3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h2F, MAX};
    vecs[4] = '{4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5E, MAX};

    // Single-requester services from reset; start delay walks the LFSR sequence.
    for (int i = 0; i < 5; i++) begin
      apple_req = 1'b0; wall_req = 1'b0; occupied = vecs[i].occ;
      do_reset();
      repeat (vecs[i].delay) @(negedge system_clk);
      apple_req = vecs[i].apple;
      wall_req  = vecs[i].wall;
      serve(vecs[i].exp_id, vecs[i].delay + 1, vecs[i].occ, 1'b1, fq, nq);
`ifndef T06_SPAWN_BORDER_EXCLUDE_EN
      check("first_query", fq, vecs[i].exp_first);
      check("query_count", nq, vecs[i].exp_nq);
`endif
      @(negedge system_clk);
      check("idle_after_done", {busy, done}, 2'b00);
    end

    // Both requesters at once: apple first, one idle cycle, then wall starts;
    // reset lands in wall's CHECK state and must discard that service.
    apple_req = 1'b0; wall_req = 1'b0; occupied = 1'b0;
    do_reset();
    apple_req = 1'b1; wall_req = 1'b1;
    serve(1'b0, 1, 1'b0, 1'b0, fq, nq);
    @(negedge system_clk);
    check("gap_busy", busy, 1'b0);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge system_clk);
      if (done) check("no_done_before_abort", done, 1'b0);
      if (query_valid) found = 1;
    end
    check("wall_query_seen", found, 1'b1);
    @(negedge system_clk);
    check("busy_in_check", busy, 1'b1);
    nreset = 1'b0;
    #2;
    outputs_zero("reset_in_check");
    @(negedge system_clk);
    check("no_done_in_reset", done, 1'b0);
    @(negedge system_clk);
    nreset = 1'b1;
    // Both still held: last-served reset to wall, so apple wins again.
    serve(1'b0, 1, 1'b0, 1'b1, fq, nq);
    @(negedge system_clk);
    check("gap_busy_2", busy, 1'b0);
    serve(1'b1, cyc + 1, 1'b0, 1'b1, fq, nq);
    @(negedge system_clk);
    check("idle_final", {busy, done, query_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
